tc_sram_requester: RTL and testbench

- Single-port initiator that drives a fixed-latency SRAM macro (req/we/addr/wdata/be in, rdata out after Latency cycles) from a valid/ready request stream.
- Returns read data on a valid/ready response stream.
- Read responses that arrive from the macro while the consumer stalls are absorbed by an internal response FIFO. A credit counter guarantees the FIFO never overflows.
- Sits between cores/DMA engines and SRAM macros with no output stall capability.

---
 rtl/tc_sram_requester.sv | 145 ++++++++++++++
 tb/tb_tc_sram_requester.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_requester.sv
// rtl/tc_sram_requester.sv - valid/ready requester for a fixed-latency SRAM macro with credit-guarded response FIFO
module tc_sram_requester #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RespDepth = 2,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam logic [CntWidth:0]   DepthSum = (CntWidth + 1)'(RespDepth);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RespDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RespDepth - 1);

    if (RespDepth < 1) begin : gen_depth_check
        $error("RespDepth must be at least 1");
    end

    logic                 accept;
    logic                 rd_accept;
    logic                 push;
    logic                 pop;
    logic                 credit_ok;
    logic [CntWidth-1:0]  inflight_q;
    logic [CntWidth-1:0]  occ_q;
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [DataWidth-1:0] mem_q [RespDepth];
    logic [DataWidth-1:0] last_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Every read holds a FIFO slot from accept until pop, so the macro can never overrun the FIFO.
    assign credit_ok   = ({1'b0, inflight_q} + {1'b0, occ_q}) < DepthSum;
    assign req_ready_o = req_we_i | credit_ok;
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;

    assign sram_req_o   = accept;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign rsp_valid_o = (occ_q != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? mem_q[rd_ptr_q] : last_q;
    assign busy_o      = (inflight_q != '0) | rsp_valid_o;

    if (Latency == 0) begin : gen_lat0
        assign push = rd_accept;
    end else begin : gen_latn
        logic [Latency-1:0] vld_q;

        // Shift read tokens toward stage 0 so the FIFO write lines up with the macro's read data
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
            end else begin
                for (int i = 0; i < int'(Latency) - 1; i++) begin
                    vld_q[i] <= vld_q[i + 1];
                end
                vld_q[Latency-1] <= rd_accept;
            end
        end

        assign push = vld_q[0];
    end

    // Count reads issued to the macro whose data has not yet landed in the FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
        end else if (rd_accept != push) begin
            inflight_q <= rd_accept ? inflight_q + CntWidth'(1) : inflight_q - CntWidth'(1);
        end
    end

    // FIFO pointers, occupancy and the last popped word shown while empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                occ_q <= occ_q + CntWidth'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - CntWidth'(1);
            end
        end
    end

    // FIFO storage captures macro read data; contents are qualified by occupancy so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sram_rdata_i;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && occ_q == DepthCnt));
    a_addr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (32'(req_addr_i) < NumWords));
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
        (!req_valid_i || $stable({req_we_i, req_addr_i, req_wdata_i, req_be_i})));
    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_rdata_o));
`endif

endmodule

// File: tb/tb_tc_sram_requester.sv
// tb/tb_tc_sram_requester.sv - self-checking bench for tc_sram_requester
module tb_tc_sram_requester;

    localparam int NW = 64;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [BW-1:0] req_be    [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          sram_req  [2];
    logic          sram_we   [2];
    logic [AW-1:0] sram_addr [2];
    logic [DW-1:0] sram_wdata[2];
    logic [BW-1:0] sram_be   [2];
    logic          busy      [2];
    logic [DW-1:0] sram_rdata0;
    logic [DW-1:0] sram_rdata1;

    tc_sram_requester #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(1), .RespDepth(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .sram_req_o(sram_req[0]), .sram_we_o(sram_we[0]), .sram_addr_o(sram_addr[0]),
        .sram_wdata_o(sram_wdata[0]), .sram_be_o(sram_be[0]), .sram_rdata_i(sram_rdata0),
        .busy_o(busy[0])
    );

    tc_sram_requester #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(0), .RespDepth(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .sram_req_o(sram_req[1]), .sram_we_o(sram_we[1]), .sram_addr_o(sram_addr[1]),
        .sram_wdata_o(sram_wdata[1]), .sram_be_o(sram_be[1]), .sram_rdata_i(sram_rdata1),
        .busy_o(busy[1])
    );

    // SRAM macro with one cycle read latency
    logic [DW-1:0] sram_mem0 [NW];
    always @(posedge clk) begin
        if (sram_req[0]) begin
            if (sram_we[0]) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[0][b]) sram_mem0[sram_addr[0]][8*b +: 8] <= sram_wdata[0][8*b +: 8];
            end else begin
                sram_rdata0 <= sram_mem0[sram_addr[0]];
            end
        end
    end

    // SRAM macro with combinational read
    logic [DW-1:0] sram_mem1 [NW];
    always @(posedge clk) begin
        if (sram_req[1] && sram_we[1]) begin
            for (int b = 0; b < BW; b++)
                if (sram_be[1][b]) sram_mem1[sram_addr[1]][8*b +: 8] <= sram_wdata[1][8*b +: 8];
        end
    end
    assign sram_rdata1 = sram_mem1[sram_addr[1]];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory image, ordered list of pending reads with visibility cycle
    int            cyc = 0;
    int            outstanding [2];
    logic [DW-1:0] last_exp    [2];
    logic [DW-1:0] ref_mem     [2][NW];
    logic [DW-1:0] q_data      [2][16];
    int            q_vis       [2][16];
    int            q_head      [2];
    int            q_tail      [2];
    logic [DW-1:0] rx          [2][64];
    int            rx_n        [2];

    function automatic int depth(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic bit exp_valid(int k);
        return (q_head[k] != q_tail[k]) && (q_vis[k][q_head[k] % 16] <= cyc);
    endfunction

    function automatic logic [DW-1:0] exp_rdata(int k);
        return exp_valid(k) ? q_data[k][q_head[k] % 16] : last_exp[k];
    endfunction

    task automatic check(string nm, int k, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, k, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic          e_vld;
            logic          e_busy;
            logic          e_rdy;
            logic [DW-1:0] e_dat;
            if (!rst_ni) begin
                e_vld = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_dat = '0;
            end else begin
                e_vld  = exp_valid(k);
                e_busy = (outstanding[k] != 0);
                e_rdy  = req_we[k] || (outstanding[k] < depth(k));
                e_dat  = exp_rdata(k);
            end
            check("req_ready", k, DW'(req_ready[k]), DW'(e_rdy));
            check("rsp_valid", k, DW'(rsp_valid[k]), DW'(e_vld));
            check("rsp_rdata", k, rsp_rdata[k], e_dat);
            check("busy", k, DW'(busy[k]), DW'(e_busy));
            check("sram_req", k, DW'(sram_req[k]), DW'(req_valid[k] && e_rdy));
            if (rst_ni && rsp_valid[k] && rsp_ready[k]) begin
                rx[k][rx_n[k]] = rsp_rdata[k];
                rx_n[k]++;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit acc_m;
            bit pop_m;
            if (!rst_ni) begin
                outstanding[k] = 0; q_head[k] = 0; q_tail[k] = 0; last_exp[k] = '0;
            end else begin
                acc_m = req_valid[k] && (req_we[k] || outstanding[k] < depth(k));
                pop_m = exp_valid(k) && rsp_ready[k];
                if (pop_m) begin
                    last_exp[k] = q_data[k][q_head[k] % 16];
                    q_head[k]++;
                    outstanding[k]--;
                end
                if (acc_m && req_we[k]) begin
                    for (int b = 0; b < BW; b++)
                        if (req_be[k][b]) ref_mem[k][req_addr[k]][8*b +: 8] = req_wdata[k][8*b +: 8];
                end
                if (acc_m && !req_we[k]) begin
                    q_data[k][q_tail[k] % 16] = ref_mem[k][req_addr[k]];
                    q_vis[k][q_tail[k] % 16]  = cyc + lat(k) + 1;
                    q_tail[k]++;
                    outstanding[k]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(int k, bit we, int addr, logic [DW-1:0] d, logic [BW-1:0] be);
        int t;
        t = 0;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = AW'(addr);
        req_wdata[k] = d; req_be[k] = be;
        #1;
        while (!req_ready[k] && t < 40) begin
            tick();
            t++;
        end
        check("send_accept_in_time", k, DW'(t < 40), DW'(1));
        check("sram_req_on_accept", k, DW'(sram_req[k]), DW'(1));
        tick();
        req_valid[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b1;
            outstanding[k] = 0; q_head[k] = 0; q_tail[k] = 0; last_exp[k] = '0; rx_n[k] = 0;
        end

        // Reset state
        tick();
        tick();
        check("reset_rsp_valid", 0, DW'(rsp_valid[0]), 32'd0);
        check("reset_busy", 0, DW'(busy[0]), 32'd0);
        check("reset_rdata", 0, rsp_rdata[0], 32'd0);
        check("reset_sram_req", 1, DW'(sram_req[1]), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Preload words 0..7
        for (int i = 0; i < 8; i++) send(0, 1'b1, i, 32'hD000_0000 + DW'(i), 4'hF);

        // Write then read the same address; response two cycles after read accept
        send(0, 1'b1, 'h10, 32'h0000_A5A5, 4'hF);
        send(0, 1'b0, 'h10, '0, '0);
        #1;
        check("t1_no_rsp_yet", 0, DW'(rsp_valid[0]), 32'd0);
        tick();
        check("t1_rsp_valid", 0, DW'(rsp_valid[0]), 32'd1);
        check("t1_rsp_rdata", 0, rsp_rdata[0], 32'h0000_A5A5);
        tick();
        check("t1_one_response", 0, DW'(rx_n[0]), 32'd1);

        // Back-to-back reads of 0..7 come back in order
        base = rx_n[0];
        for (int i = 0; i < 8; i++) send(0, 1'b0, i, '0, '0);
        for (int i = 0; i < 6; i++) tick();
        check("t2_count", 0, DW'(rx_n[0] - base), 32'd8);
        for (int i = 0; i < 8; i++) check("t2_order", 0, rx[0][base + i], 32'hD000_0000 + DW'(i));

        // Stalled consumer: two reads take all credits, writes still go through
        base = rx_n[0];
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 1, '0, '0);
        send(0, 1'b0, 2, '0, '0);
        #1;
        check("t3_read_blocked", 0, DW'(req_ready[0]), 32'd0);
        req_we[0] = 1'b1;
        #1;
        check("t3_write_ready", 0, DW'(req_ready[0]), 32'd1);
        send(0, 1'b1, 'h20, 32'h1234_5678, 4'hF);
        rsp_ready[0] = 1'b1;
        send(0, 1'b0, 3, '0, '0);
        send(0, 1'b0, 4, '0, '0);
        for (int i = 0; i < 6; i++) tick();
        check("t3_count", 0, DW'(rx_n[0] - base), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_order", 0, rx[0][base + i], 32'hD000_0001 + DW'(i));

        // Zero latency, single credit
        rsp_ready[1] = 1'b0;
        send(1, 1'b1, 3, 32'h0000_0077, 4'hF);
        send(1, 1'b0, 3, '0, '0);
        #1;
        check("t4_rsp_valid", 1, DW'(rsp_valid[1]), 32'd1);
        check("t4_rsp_rdata", 1, rsp_rdata[1], 32'h0000_0077);
        check("t4_blocked", 1, DW'(req_ready[1]), 32'd0);
        tick();
        check("t4_still_blocked", 1, DW'(req_ready[1]), 32'd0);
        rsp_ready[1] = 1'b1;
        #1;
        check("t4_pop_cycle_blocked", 1, DW'(req_ready[1]), 32'd0);
        tick();
        check("t4_credit_back", 1, DW'(req_ready[1]), 32'd1);
        check("t4_empty", 1, DW'(rsp_valid[1]), 32'd0);

        // Partial write of the low byte
        send(0, 1'b1, 'h30, 32'hFFFF_FFFF, 4'hF);
        send(0, 1'b1, 'h30, 32'h0000_0000, 4'b0001);
        send(0, 1'b0, 'h30, '0, '0);
        for (int i = 0; i < 3; i++) tick();
        check("t5_partial", 0, rx[0][rx_n[0] - 1], 32'hFFFF_FF00);

        // Reset with one read in flight and one buffered
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 5, '0, '0);
        send(0, 1'b0, 6, '0, '0);
        check("t6_pre_valid", 0, DW'(rsp_valid[0]), 32'd1);
        check("t6_pre_busy", 0, DW'(busy[0]), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", 0, DW'(rsp_valid[0]), 32'd0);
        check("t6_rst_busy", 0, DW'(busy[0]), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        rsp_ready[0] = 1'b1;
        base = rx_n[0];
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_stale", 0, DW'(rx_n[0] - base), 32'd0);
        check("t6_ready", 0, DW'(req_ready[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
